// File: rtl/dpi_stream_sequencer.sv
// Front-end sequencer for the regex matcher bank: resolves each packet's flow key
// to a stream slot, then drives restore, payload and end-of-packet on the shared bus.
module dpi_stream_sequencer #(
   parameter int KEY_W    = 32,
   parameter int DEPTH    = 64,
   parameter int LOAD_GAP = 2,
   parameter int EOP_GAP  = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [7:0]       s_data,
   input  logic             s_valid,
   input  logic             s_sop,
   input  logic             s_eop,
   input  logic [KEY_W-1:0] s_key,
   output logic             s_ready,
   input  logic [63:0]      enable_map,
   output logic [7:0]       char_in,
   output logic             char_in_vld,
   output logic             load_state,
   output logic             new_stream_id,
   output logic [5:0]       stream_id,
   output logic             enable,
   output logic             eop,
   output logic [31:0]      pkt_count
);

   typedef enum logic [2:0] {
      ST_IDLE, ST_LOOKUP, ST_LOAD, ST_WAIT, ST_FIRST, ST_STREAM, ST_LAST, ST_DRAIN
   } state_t;

   localparam logic [7:0] SCAN_LAST  = 8'(DEPTH - 1);
   localparam logic [7:0] LOAD_LAST  = 8'(LOAD_GAP - 1);
   localparam logic [7:0] DRAIN_LAST = 8'(EOP_GAP - 1);
   localparam logic [5:0] RP_LAST    = 6'(DEPTH - 1);

   state_t           state_r;
   state_t           next_s;
   logic             eop_phase_r;
   logic [7:0]       cnt_r;
   logic [KEY_W-1:0] key_r;
   logic [7:0]       first_byte_r;
   logic             first_eop_r;
   logic [KEY_W-1:0] key_mem_r [DEPTH];
   logic [DEPTH-1:0] valid_r;
   logic [5:0]       rp_r;
   logic             hit_found_r;
   logic [5:0]       hit_idx_r;
   logic             inv_found_r;
   logic [5:0]       inv_idx_r;

   logic [5:0]       idx_s;
   logic             match_s;
   logic             free_s;
   logic             hit_s;
   logic             inv_s;
   logic [5:0]       result_id_s;
   logic             accept_sop_s;
   logic             scan_done_s;
   logic             alloc_s;
   logic             eop_next_s;

   logic             s_ready_s;
   logic [7:0]       char_in_s;
   logic             char_in_vld_s;
   logic             load_state_s;
   logic             new_stream_id_s;

   // Scan compare for the entry under the cursor, folded with the results found so far
   always_comb begin
      idx_s        = cnt_r[5:0];
      match_s      = valid_r[idx_s] && (key_mem_r[idx_s] == key_r);
      free_s       = !valid_r[idx_s];
      hit_s        = hit_found_r || match_s;
      inv_s        = inv_found_r || free_s;
      accept_sop_s = (state_r == ST_IDLE) && s_ready && s_valid && s_sop;
      scan_done_s  = (state_r == ST_LOOKUP) && (cnt_r == SCAN_LAST);
      alloc_s      = scan_done_s && !hit_s;
      if (hit_found_r) begin
         result_id_s = hit_idx_r;
      end else if (match_s) begin
         result_id_s = idx_s;
      end else if (inv_found_r) begin
         result_id_s = inv_idx_r;
      end else if (free_s) begin
         result_id_s = idx_s;
      end else begin
         result_id_s = rp_r;
      end
   end

   // State register; EOP shares the drain encoding and is tracked by eop_phase_r
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= ST_IDLE;
         eop_phase_r <= 1'b0;
         cnt_r       <= 8'd0;
      end else begin
         state_r     <= next_s;
         eop_phase_r <= eop_next_s;
         cnt_r       <= (next_s != state_r || eop_next_s) ? 8'd0 : cnt_r + 8'd1;
      end
   end

   // Next-state logic
   always_comb begin
      next_s     = state_r;
      eop_next_s = 1'b0;
      case (state_r)
         ST_IDLE:   next_s = accept_sop_s ? ST_LOOKUP : ST_IDLE;
         ST_LOOKUP: next_s = scan_done_s ? ST_LOAD : ST_LOOKUP;
         ST_LOAD:   next_s = ST_WAIT;
         ST_WAIT:   next_s = (cnt_r == LOAD_LAST) ? ST_FIRST : ST_WAIT;
         ST_FIRST: begin
            if (first_eop_r) begin
               next_s = ST_DRAIN;
            end else if (s_valid && s_eop) begin
               next_s = ST_LAST;
            end else begin
               next_s = ST_STREAM;
            end
         end
         ST_STREAM: next_s = (s_valid && s_eop) ? ST_LAST : ST_STREAM;
         ST_LAST:   next_s = ST_DRAIN;
         ST_DRAIN: begin
            if (eop_phase_r) begin
               next_s = ST_IDLE;
            end else if (cnt_r == DRAIN_LAST) begin
               next_s     = ST_DRAIN;
               eop_next_s = 1'b1;
            end else begin
               next_s = ST_DRAIN;
            end
         end
         default:   next_s = ST_IDLE;
      endcase
   end

   // Output decode, evaluated one cycle ahead so every output leaves a flop
   always_comb begin
      s_ready_s       = 1'b0;
      char_in_s       = 8'd0;
      char_in_vld_s   = 1'b0;
      load_state_s    = (next_s == ST_LOAD);
      new_stream_id_s = (next_s == ST_LOAD) && !hit_s;
      case (next_s)
         ST_IDLE:   s_ready_s = 1'b1;
         ST_FIRST:  s_ready_s = !first_eop_r;
         ST_STREAM: s_ready_s = 1'b1;
         default:   s_ready_s = 1'b0;
      endcase
      if (next_s == ST_FIRST) begin
         char_in_s     = first_byte_r;
         char_in_vld_s = 1'b1;
      end else if ((state_r == ST_FIRST || state_r == ST_STREAM) && s_ready && s_valid) begin
         char_in_s     = s_data;
         char_in_vld_s = 1'b1;
      end else begin
         char_in_s     = 8'd0;
         char_in_vld_s = 1'b0;
      end
   end

   // Output registers; stream_id and enable are captured at restore and held
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s_ready       <= 1'b0;
         char_in       <= 8'd0;
         char_in_vld   <= 1'b0;
         load_state    <= 1'b0;
         new_stream_id <= 1'b0;
         stream_id     <= 6'd0;
         enable        <= 1'b0;
         eop           <= 1'b0;
         pkt_count     <= 32'd0;
      end else begin
         s_ready       <= s_ready_s;
         char_in       <= char_in_s;
         char_in_vld   <= char_in_vld_s;
         load_state    <= load_state_s;
         new_stream_id <= new_stream_id_s;
         eop           <= eop_next_s;
         pkt_count     <= eop_next_s ? pkt_count + 32'd1 : pkt_count;
         if (load_state_s) begin
            stream_id <= result_id_s;
            enable    <= enable_map[result_id_s];
         end
      end
   end

   // Packet context, scan bookkeeping and table valid bits / replacement pointer
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         key_r        <= '0;
         first_byte_r <= 8'd0;
         first_eop_r  <= 1'b0;
         valid_r      <= '0;
         rp_r         <= 6'd0;
         hit_found_r  <= 1'b0;
         hit_idx_r    <= 6'd0;
         inv_found_r  <= 1'b0;
         inv_idx_r    <= 6'd0;
      end else begin
         if (accept_sop_s) begin
            key_r        <= s_key;
            first_byte_r <= s_data;
            first_eop_r  <= s_eop;
            hit_found_r  <= 1'b0;
            inv_found_r  <= 1'b0;
         end
         if (state_r == ST_LOOKUP) begin
            if (!hit_found_r && match_s) begin
               hit_found_r <= 1'b1;
               hit_idx_r   <= idx_s;
            end
            if (!inv_found_r && free_s) begin
               inv_found_r <= 1'b1;
               inv_idx_r   <= idx_s;
            end
         end
         if (alloc_s) begin
            valid_r[result_id_s] <= 1'b1;
            if (!inv_s) begin
               rp_r <= (rp_r == RP_LAST) ? 6'd0 : rp_r + 6'd1;
            end
         end
      end
   end

   // Key storage carries no reset; entries are meaningful only behind their valid bit
   always_ff @(posedge clk) begin
      if (alloc_s) begin
         key_mem_r[result_id_s] <= key_r;
      end
   end

endmodule

// File: tb/tb_dpi_stream_sequencer.sv
// Directed bench for dpi_stream_sequencer: table-driven packets plus hand-written
// sequences for table eviction and reset in the middle of a packet.
module tb_dpi_stream_sequencer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [7:0]  s_data;
   logic        s_valid;
   logic        s_sop;
   logic        s_eop;
   logic [31:0] s_key;
   logic        s_ready;
   logic [63:0] enable_map;
   logic [7:0]  char_in;
   logic        char_in_vld;
   logic        load_state;
   logic        new_stream_id;
   logic [5:0]  stream_id;
   logic        enable;
   logic        eop;
   logic [31:0] pkt_count;

   int checks = 0;
   int errors = 0;
   int pkts_done = 0;

   int cyc = 0;
   int load_cnt = 0;
   int eop_cnt = 0;
   int load_cyc = 0;
   int eop_cyc = 0;
   int first_char_cyc = -1;
   int last_char_cyc = 0;
   logic [5:0] load_id, eop_id;
   logic       load_new, load_en, eop_en;
   logic [7:0] rx_q[$];

   typedef struct {
      logic [31:0] key;
      int          nbytes;
      logic [7:0]  gaps;
      logic [63:0] emap;
      logic [5:0]  exp_id;
      logic        exp_new;
      logic        exp_en;
   } vec_t;

   vec_t vecs[7];

   dpi_stream_sequencer dut (
      .clk(clk), .rst_n(rst_n), .s_data(s_data), .s_valid(s_valid), .s_sop(s_sop),
      .s_eop(s_eop), .s_key(s_key), .s_ready(s_ready), .enable_map(enable_map),
      .char_in(char_in), .char_in_vld(char_in_vld), .load_state(load_state),
      .new_stream_id(new_stream_id), .stream_id(stream_id), .enable(enable),
      .eop(eop), .pkt_count(pkt_count)
   );

   always #5 clk = ~clk;

   // Event monitor: captures strobes on the falling edge and checks they never overlap
   always @(negedge clk) begin
      cyc++;
      if (load_state) begin
         load_cnt++;
         load_cyc = cyc;
         load_id = stream_id;
         load_new = new_stream_id;
         load_en = enable;
         rx_q.delete();
         first_char_cyc = -1;
      end
      if (char_in_vld) begin
         if (first_char_cyc < 0) first_char_cyc = cyc;
         last_char_cyc = cyc;
         rx_q.push_back(char_in);
      end
      if (eop) begin
         eop_cnt++;
         eop_cyc = cyc;
         eop_id = stream_id;
         eop_en = enable;
      end
      if (load_state || eop || char_in_vld) begin
         checks++;
         if ((int'(load_state) + int'(eop) + int'(char_in_vld)) > 1) begin
            errors++;
            $display("FAIL strobe_overlap cycle=%0d load=%0b eop=%0b vld=%0b required at most one",
                     cyc, load_state, eop, char_in_vld);
         end
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic timeout_fail(input string name);
      checks++;
      errors++;
      $display("FAIL %s actual=timeout required=event", name);
   endtask

   function automatic logic [7:0] byte_of(input logic [31:0] key, input int i);
      return key[7:0] ^ 8'(8'h30 + i);
   endfunction

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic run_pkt(input logic [31:0] key, input int nbytes, input logic [7:0] gaps,
                          input logic [5:0] exp_id, input logic exp_new, input logic exp_en);
      int t;
      int sent;
      int eop0;
      int load0;
      bit gap_done;
      eop0 = eop_cnt;
      load0 = load_cnt;
      t = 0;
      while (!s_ready && t < 200) begin
         tick();
         t++;
      end
      if (!s_ready) timeout_fail("sop_ready");
      s_valid = 1'b1;
      s_sop = 1'b1;
      s_eop = (nbytes == 1);
      s_data = byte_of(key, 0);
      s_key = key;
      tick();
      s_valid = 1'b0;
      s_sop = 1'b0;
      s_eop = 1'b0;
      sent = 1;
      gap_done = 1'b0;
      t = 0;
      while (sent < nbytes && t < 400) begin
         if (s_ready && gaps[sent[2:0]] && !gap_done) begin
            s_valid = 1'b0;
            gap_done = 1'b1;
         end else if (s_ready) begin
            s_valid = 1'b1;
            s_data = byte_of(key, sent);
            s_eop = (sent == nbytes - 1);
            sent++;
            gap_done = 1'b0;
         end else begin
            s_valid = 1'b0;
         end
         tick();
         t++;
      end
      s_valid = 1'b0;
      s_eop = 1'b0;
      if (sent < nbytes) timeout_fail("payload_ready");
      t = 0;
      while (eop_cnt == eop0 && t < 200) begin
         tick();
         t++;
      end
      if (eop_cnt == eop0) timeout_fail("eop_wait");
      pkts_done++;
      tick();
      chk("load_once", 64'(load_cnt - load0), 64'd1);
      chk("eop_once", 64'(eop_cnt - eop0), 64'd1);
      chk("load_stream_id", 64'(load_id), 64'(exp_id));
      chk("new_stream_id", 64'(load_new), 64'(exp_new));
      chk("load_enable", 64'(load_en), 64'(exp_en));
      chk("byte_count", 64'(rx_q.size()), 64'(nbytes));
      for (int i = 0; i < nbytes && i < rx_q.size(); i++)
         chk("byte_value", 64'(rx_q[i]), 64'(byte_of(key, i)));
      chk("load_to_first_char", 64'(first_char_cyc - load_cyc), 64'd3);
      chk("last_char_to_eop", 64'(eop_cyc - last_char_cyc), 64'd4);
      chk("eop_stream_id", 64'(eop_id), 64'(exp_id));
      chk("eop_enable", 64'(eop_en), 64'(exp_en));
      chk("pkt_count", 64'(pkt_count), 64'(pkts_done));
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      repeat (3) tick();
      rst_n = 1'b1;
      tick();
      pkts_done = 0;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int t;
      int eop0;
      vecs[0] = '{32'hA, 4, 8'h00, {64{1'b1}}, 6'd0, 1'b1, 1'b1};
      vecs[1] = '{32'hB, 2, 8'h00, {64{1'b1}}, 6'd1, 1'b1, 1'b1};
      vecs[2] = '{32'hA, 3, 8'h00, {64{1'b1}}, 6'd0, 1'b0, 1'b1};
      vecs[3] = '{32'hB, 2, 8'h00, 64'h2,      6'd1, 1'b0, 1'b1};
      vecs[4] = '{32'hA, 2, 8'h00, 64'h2,      6'd0, 1'b0, 1'b0};
      vecs[5] = '{32'hC, 1, 8'h00, 64'h2,      6'd2, 1'b1, 1'b0};
      vecs[6] = '{32'hD, 3, 8'h06, 64'h2,      6'd3, 1'b1, 1'b0};

      rst_n = 1'b0;
      s_data = 8'd0;
      s_valid = 1'b0;
      s_sop = 1'b0;
      s_eop = 1'b0;
      s_key = 32'd0;
      enable_map = {64{1'b1}};
      repeat (3) tick();
      chk("reset_outputs", {12'd0, s_ready, char_in, char_in_vld, load_state, new_stream_id,
                            stream_id, enable, eop, pkt_count}, 64'd0);
      rst_n = 1'b1;
      tick();
      chk("idle_ready", 64'(s_ready), 64'd1);

      foreach (vecs[i]) begin
         enable_map = vecs[i].emap;
         run_pkt(vecs[i].key, vecs[i].nbytes, vecs[i].gaps,
                 vecs[i].exp_id, vecs[i].exp_new, vecs[i].exp_en);
      end

      // Reset while the first payload byte is on the bus and a second is offered
      enable_map = {64{1'b1}};
      t = 0;
      while (!s_ready && t < 200) begin tick(); t++; end
      s_valid = 1'b1; s_sop = 1'b1; s_eop = 1'b0; s_key = 32'h55; s_data = 8'h11;
      tick();
      s_valid = 1'b0; s_sop = 1'b0;
      t = 0;
      while (!char_in_vld && t < 200) begin tick(); t++; end
      if (!char_in_vld) timeout_fail("mid_reset_stream");
      eop0 = eop_cnt;
      s_valid = 1'b1; s_data = 8'h22;
      rst_n = 1'b0;
      #1;
      chk("mid_reset_outputs", {12'd0, s_ready, char_in, char_in_vld, load_state, new_stream_id,
                                stream_id, enable, eop, pkt_count}, 64'd0);
      s_valid = 1'b0;
      repeat (3) tick();
      rst_n = 1'b1;
      repeat (80) tick();
      chk("mid_reset_no_eop", 64'(eop_cnt - eop0), 64'd0);
      pkts_done = 0;
      run_pkt(32'h77, 2, 8'h00, 6'd0, 1'b1, 1'b1);

      // Fill every slot, then evict through the replacement pointer
      do_reset();
      for (int k = 0; k < 64; k++)
         run_pkt(32'(k), 2, 8'h00, 6'(k), 1'b1, 1'b1);
      run_pkt(32'hFFFF, 2, 8'h00, 6'd0, 1'b1, 1'b1);
      run_pkt(32'h10000, 1, 8'h00, 6'd1, 1'b1, 1'b1);
      run_pkt(32'h0, 2, 8'h00, 6'd2, 1'b1, 1'b1);
      run_pkt(32'h1, 2, 8'h00, 6'd3, 1'b1, 1'b1);
      run_pkt(32'h5, 3, 8'h02, 6'd5, 1'b0, 1'b1);
      run_pkt(32'hFFFF, 1, 8'h00, 6'd0, 1'b0, 1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
